// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared state encoding, mode constants and popcount helper for the PUF controller
package puf_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RDY, S_RELEASE, S_FINISH} state_t;
  localparam logic MODE_ENROLL = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/response_store.sv
// response_store: NUM_CHALL x 8 enrolled-response register file, sync active-low clear, shared write/read index
module response_store #(
  parameter int NUM_CHALL = 4,
  localparam int IW = NUM_CHALL > 1 ? $clog2(NUM_CHALL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [NUM_CHALL];
  // clear on reset, otherwise write the captured response at the current index
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHALL; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/puf_challenge_controller.sv
// puf_challenge_controller: runs enroll/verify challenge sessions against a ring-oscillator PUF
module puf_challenge_controller
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_CHALL = 4,
  parameter int THRESH = 4,
  parameter int TIMEOUT = 4096,
  localparam int HDW = $clog2(8 * NUM_CHALL + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [7:0]     base_chall,
  output logic           puf_en,
  output logic [7:0]     puf_chall,
  input  logic [7:0]     puf_response,
  input  logic           puf_ready,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           enrolled,
  output logic [HDW-1:0] hd_total,
  output logic           timeout_err
);
  localparam int IW = NUM_CHALL > 1 ? $clog2(NUM_CHALL) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t r_state, w_next;
  logic r_mode, r_rdy_q, r_en, r_pass, r_enrolled, r_tout;
  logic [7:0] r_base, r_chall, w_stored;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [HDW-1:0] r_hd;
  logic w_rise, w_last, w_expire, w_cap, w_abort, w_fin_ok;
  assign w_rise   = puf_ready & ~r_rdy_q;
  assign w_last   = r_idx == IW'(NUM_CHALL - 1);
  assign w_expire = r_cnt == CW'(TIMEOUT - 1);
  assign w_cap    = r_state == S_WAIT_RDY && w_rise;
  assign w_abort  = w_expire && ((r_state == S_WAIT_RDY && !w_rise) || (r_state == S_RELEASE && puf_ready));
  assign w_fin_ok = r_state == S_RELEASE && !puf_ready && w_last;
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_FINISH;
  assign puf_en      = r_en;
  assign puf_chall   = r_chall;
  assign pass        = r_pass;
  assign enrolled    = r_enrolled;
  assign hd_total    = r_hd;
  assign timeout_err = r_tout;
  response_store #(.NUM_CHALL(NUM_CHALL)) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cap && r_mode == MODE_ENROLL),
    .i_idx   (r_idx),
    .i_wdata (puf_response),
    .o_rdata (w_stored)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next-state: capture beats a coincident timeout; verifying with nothing enrolled ends immediately
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (mode == MODE_VERIFY && !r_enrolled) ? S_FINISH : S_ISSUE;
      S_ISSUE:    w_next = S_WAIT_RDY;
      S_WAIT_RDY: w_next = w_cap ? S_RELEASE : w_abort ? S_FINISH : S_WAIT_RDY;
      S_RELEASE:  w_next = !puf_ready ? (w_last ? S_FINISH : S_ISSUE) : w_abort ? S_FINISH : S_RELEASE;
      default:    w_next = S_IDLE;
    endcase
  end
  // session datapath: verdict is settled on the edge entering FINISH so it is valid alongside done
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode <= 1'b0;
      r_base <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_rdy_q <= 1'b0;
      r_en <= 1'b0;
      r_chall <= '0;
      r_pass <= 1'b0;
      r_enrolled <= 1'b0;
      r_tout <= 1'b0;
      r_hd <= '0;
    end else begin
      r_rdy_q <= puf_ready;
      r_cnt <= (w_next == r_state) ? r_cnt + CW'(1) : '0;
      r_en <= w_next == S_WAIT_RDY;
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_base <= base_chall;
        r_idx <= '0;
        r_pass <= 1'b0;
        r_hd <= '0;
        r_tout <= 1'b0;
        if (mode == MODE_ENROLL) r_enrolled <= 1'b0;
      end
      if (r_state == S_ISSUE) r_chall <= r_base + 8'(r_idx);
      if (w_cap && r_mode == MODE_VERIFY) r_hd <= r_hd + HDW'(popcount8(puf_response ^ w_stored));
      if (r_state == S_RELEASE && !puf_ready && !w_last) r_idx <= r_idx + IW'(1);
      if (w_abort) r_tout <= 1'b1;
      if (w_fin_ok) begin
        r_pass <= r_mode == MODE_ENROLL || int'(r_hd) <= THRESH;
        if (r_mode == MODE_ENROLL) r_enrolled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_puf_challenge_controller.sv
// tb_puf_challenge_controller: scoreboard bench with a behavioural ring-oscillator PUF model
module tb_puf_challenge_controller;
  localparam int N = 4, TH = 4, TO = 16, RDY_DLY = 2;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [7:0] base_chall = '0, puf_response = '0, puf_chall;
  logic puf_ready = 1'b0, puf_en, busy, done, pass, enrolled, timeout_err;
  logic [5:0] hd_total;
  int tests = 0, fails = 0, done_cnt = 0, en_rises = 0, hi = 0, lo = 0;
  logic model_live = 1'b1, en_q = 1'b0, done_q = 1'b0;
  logic [7:0] flip [4];
  typedef struct packed {logic p; logic [5:0] hd; logic t; logic e;} exp_t;
  exp_t sb[$];
  exp_t mx;
  logic [7:0] cq[$];

  always #5 clk = ~clk;

  puf_challenge_controller #(.NUM_CHALL(N), .THRESH(TH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_chall(base_chall),
    .puf_en(puf_en), .puf_chall(puf_chall), .puf_response(puf_response), .puf_ready(puf_ready),
    .busy(busy), .done(done), .pass(pass), .enrolled(enrolled), .hd_total(hd_total),
    .timeout_err(timeout_err)
  );

  function automatic logic [7:0] f(input logic [7:0] c);
    return {c[3:0], c[7:4]} ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PUF model: ready rises RDY_DLY cycles into enable, falls 2 cycles after enable drops
  always @(negedge clk) begin
    if (puf_en) begin
      lo = 0;
      if (!puf_ready && model_live) begin
        hi++;
        if (hi >= RDY_DLY) begin
          puf_response = f(puf_chall) ^ flip[puf_chall[1:0]];
          puf_ready = 1'b1;
        end
      end
    end else begin
      hi = 0;
      if (puf_ready) begin
        lo++;
        if (lo >= 2) begin
          puf_ready = 1'b0;
          lo = 0;
        end
      end
    end
  end

  // monitor: challenge order on each enable rise, verdict on each done pulse
  always @(negedge clk) begin
    if (puf_en && !en_q) begin
      en_rises++;
      if (cq.size() == 0) chk("unexpected_puf_en", 1, 0);
      else chk("puf_chall", int'(puf_chall), int'(cq.pop_front()));
    end
    if (done) begin
      chk("done_width", int'(done_q), 0);
      chk("busy_at_done", int'(busy), 1);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mx = sb.pop_front();
        chk("pass", int'(pass), int'(mx.p));
        chk("hd_total", int'(hd_total), int'(mx.hd));
        chk("timeout_err", int'(timeout_err), int'(mx.t));
        chk("enrolled", int'(enrolled), int'(mx.e));
      end
      done_cnt++;
    end
    en_q = puf_en;
    done_q = done;
  end

  task automatic session(input logic m, input logic [7:0] b, input int nch, input logic p,
                         input int hd, input logic t, input logic e, input bit poke);
    int tgt;
    for (int i = 0; i < nch; i++) cq.push_back(b + 8'(i));
    sb.push_back('{p, 6'(hd), t, e});
    tgt = done_cnt + 1;
    @(negedge clk);
    start = 1'b1; mode = m; base_chall = b;
    @(negedge clk);
    start = 1'b0; mode = ~m; base_chall = 8'h55;
    if (poke) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 600 && done_cnt < tgt; i++) @(negedge clk);
    chk("session_done", done_cnt, tgt);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, er0, tgt;
    foreach (flip[i]) flip[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({puf_en, puf_chall, busy, done, pass, enrolled, hd_total, timeout_err}), 0);
    rst = 1'b1;
    @(negedge clk);
    // verify straight after reset: nothing enrolled, no PUF traffic
    er0 = en_rises;
    sb.push_back('{1'b0, 6'd0, 1'b0, 1'b0});
    start = 1'b1; mode = 1'b1; base_chall = 8'hFE;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) break;
    end
    chk("unenrolled_done_within_2", int'(lat <= 2), 1);
    repeat (3) @(negedge clk);
    chk("unenrolled_no_puf_en", en_rises, er0);
    // enrollment wrapping through 0xFF -> 0x00
    session(1'b0, 8'hFE, 4, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    // clean verify, with an ignored start poke mid-session
    session(1'b1, 8'hFE, 4, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    flip[2] = 8'h03; flip[3] = 8'h10; flip[0] = 8'h81;
    session(1'b1, 8'hFE, 4, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    flip[0] = 8'h01;
    session(1'b1, 8'hFE, 4, 1'b1, 4, 1'b0, 1'b1, 1'b0);
    foreach (flip[i]) flip[i] = 8'h00;
    model_live = 1'b0;
    session(1'b1, 8'hFE, 1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    session(1'b0, 8'hFE, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    model_live = 1'b1;
    session(1'b0, 8'h10, 4, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    // reset during the second challenge of a verify
    cq.push_back(8'h10); cq.push_back(8'h11);
    tgt = en_rises + 2;
    start = 1'b1; mode = 1'b1; base_chall = 8'h10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && en_rises < tgt; i++) @(negedge clk);
    chk("second_challenge_reached", en_rises, tgt);
    start = 1'b1; mode = 1'b0; base_chall = 8'h77;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", int'(busy), 1);
    chk("busy_start_keeps_enrolled", int'(enrolled), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", int'({puf_en, puf_chall, busy, done, pass, hd_total, timeout_err}), 0);
    chk("midreset_enrolled", int'(enrolled), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    session(1'b1, 8'h10, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("queues_drained", sb.size() + cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
